// File: rtl/yuv_to_rgb_sram_converter.sv
// yuv_to_rgb_sram_converter
// Reads a YUV 4:4:4 frame (two pixels per word per plane) from SRAM and writes
// it back as packed RGB888, three words per pixel pair.
// Optional feature: define CSC_CLIP_COUNT_EN to add the Clip_count output,
// which counts the number of clipped colour components.
module yuv_to_rgb_sram_converter #(
  parameter logic [17:0] Y_BASE      = 18'd0,
  parameter logic [17:0] U_BASE      = 18'd38400,
  parameter logic [17:0] V_BASE      = 18'd76800,
  parameter logic [17:0] RGB_BASE    = 18'd146944,
  parameter logic [16:0] NUM_PAIRS   = 17'd38400,
  parameter int          SRAM_RD_LAT = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  output logic        Busy,
  output logic        Done,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data
`ifdef CSC_CLIP_COUNT_EN
  ,
  output logic [17:0] Clip_count
`endif
);

  localparam int DATA_W = 8;

  // Conversion coefficients, scaled by 2^16
  localparam logic signed [31:0] C_Y  = 32'sd76284;
  localparam logic signed [31:0] C_RV = 32'sd104595;
  localparam logic signed [31:0] C_GU = 32'sd25624;
  localparam logic signed [31:0] C_GV = 32'sd53281;
  localparam logic signed [31:0] C_BU = 32'sd132251;

  localparam logic [16:0] LAST_PAIR = NUM_PAIRS - 17'd1;
  localparam logic [7:0]  WAIT_LAST = 8'(SRAM_RD_LAT - 2);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_Y, S_RD_U, S_RD_V, S_WAIT, S_CAP,
    S_CALC0, S_CALC1, S_WR0, S_WR1, S_WR2, S_DONE
  } state_t;

  typedef enum logic [1:0] {TAG_NONE, TAG_Y, TAG_U, TAG_V} rd_tag_t;

  state_t      state, state_n;
  logic [16:0] pair_cnt, pair_cnt_n;
  logic [17:0] rgb_ptr, rgb_ptr_n;
  logic [7:0]  wait_cnt, wait_cnt_n;
  logic        start_acc;

  rd_tag_t     rd_tag_now;
  rd_tag_t     rd_tag_p [SRAM_RD_LAT];

  logic [2*DATA_W-1:0] y_word, u_word, v_word;

  logic signed [31:0] yk_p1 [2];
  logic signed [31:0] rv_p1 [2];
  logic signed [31:0] gu_p1 [2];
  logic signed [31:0] gv_p1 [2];
  logic signed [31:0] bu_p1 [2];

  logic signed [31:0] r_acc [2];
  logic signed [31:0] g_acc [2];
  logic signed [31:0] b_acc [2];

  logic [DATA_W-1:0] r_c [2];
  logic [DATA_W-1:0] g_c [2];
  logic [DATA_W-1:0] b_c [2];
  logic [DATA_W-1:0] r_p2 [2];
  logic [DATA_W-1:0] g_p2 [2];
  logic [DATA_W-1:0] b_p2 [2];

  // Unsigned 8-bit sample minus a bias, as a signed 32-bit value
  function automatic logic signed [31:0] offs(input logic [DATA_W-1:0] x,
                                              input logic signed [31:0] bias);
    return $signed({{(32-DATA_W){1'b0}}, x}) - bias;
  endfunction

  // Floor-shift by 16 and clip to 0..255
  function automatic logic [DATA_W-1:0] clip_pix(input logic signed [31:0] acc);
    logic signed [31:0] s;
    s = acc >>> 16;
    if (s < 32'sd0)        return '0;
    else if (s > 32'sd255) return '1;
    else                   return s[DATA_W-1:0];
  endfunction

  // True when clip_pix would have saturated this accumulator
  function automatic logic is_clipped(input logic signed [31:0] acc);
    logic signed [31:0] s;
    s = acc >>> 16;
    return (s < 32'sd0) || (s > 32'sd255);
  endfunction

  assign start_acc = (state == S_IDLE) && Start;

  // State register and frame-level counters
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= S_IDLE;
      pair_cnt <= '0;
      rgb_ptr  <= RGB_BASE;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      pair_cnt <= pair_cnt_n;
      rgb_ptr  <= rgb_ptr_n;
      wait_cnt <= wait_cnt_n;
    end
  end

  // Next-state logic and counter updates
  always_comb begin
    state_n    = state;
    pair_cnt_n = pair_cnt;
    rgb_ptr_n  = rgb_ptr;
    wait_cnt_n = wait_cnt;
    case (state)
      S_IDLE: begin
        if (Start) begin
          state_n    = S_RD_Y;
          pair_cnt_n = '0;
          rgb_ptr_n  = RGB_BASE;
        end
      end
      S_RD_Y: state_n = S_RD_U;
      S_RD_U: state_n = S_RD_V;
      S_RD_V: begin
        wait_cnt_n = '0;
        state_n    = (SRAM_RD_LAT > 1) ? S_WAIT : S_CAP;
      end
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) state_n = S_CAP;
        else                       wait_cnt_n = wait_cnt + 8'd1;
      end
      S_CAP:   state_n = S_CALC0;
      S_CALC0: state_n = S_CALC1;
      S_CALC1: state_n = S_WR0;
      S_WR0:   state_n = S_WR1;
      S_WR1:   state_n = S_WR2;
      S_WR2: begin
        if (pair_cnt == LAST_PAIR) begin
          state_n = S_DONE;
        end else begin
          state_n    = S_RD_Y;
          pair_cnt_n = pair_cnt + 17'd1;
          rgb_ptr_n  = rgb_ptr + 18'd3;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Tag the plane being read this cycle so the returning word can be routed
  always_comb begin
    rd_tag_now = TAG_NONE;
    case (state)
      S_RD_Y:  rd_tag_now = TAG_Y;
      S_RD_U:  rd_tag_now = TAG_U;
      S_RD_V:  rd_tag_now = TAG_V;
      default: rd_tag_now = TAG_NONE;
    endcase
  end

  // Delay the read tags by the SRAM read latency
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < SRAM_RD_LAT; i++) rd_tag_p[i] <= TAG_NONE;
    end else begin
      rd_tag_p[0] <= rd_tag_now;
      for (int i = 1; i < SRAM_RD_LAT; i++) rd_tag_p[i] <= rd_tag_p[i-1];
    end
  end

  // Capture returning Y/U/V words when their tag emerges from the delay line
  always_ff @(posedge Clock) begin
    if (rd_tag_p[SRAM_RD_LAT-1] == TAG_Y) y_word <= SRAM_read_data;
    if (rd_tag_p[SRAM_RD_LAT-1] == TAG_U) u_word <= SRAM_read_data;
    if (rd_tag_p[SRAM_RD_LAT-1] == TAG_V) v_word <= SRAM_read_data;
  end

  // ---- stage p1: coefficient products (index 0 = high byte = pixel 0) ----
  // Register all products for both pixels in S_CALC0
  always_ff @(posedge Clock) begin
    if (state == S_CALC0) begin
      yk_p1[0] <= C_Y  * offs(y_word[2*DATA_W-1:DATA_W], 32'sd16);
      yk_p1[1] <= C_Y  * offs(y_word[DATA_W-1:0],        32'sd16);
      rv_p1[0] <= C_RV * offs(v_word[2*DATA_W-1:DATA_W], 32'sd128);
      rv_p1[1] <= C_RV * offs(v_word[DATA_W-1:0],        32'sd128);
      gu_p1[0] <= C_GU * offs(u_word[2*DATA_W-1:DATA_W], 32'sd128);
      gu_p1[1] <= C_GU * offs(u_word[DATA_W-1:0],        32'sd128);
      gv_p1[0] <= C_GV * offs(v_word[2*DATA_W-1:DATA_W], 32'sd128);
      gv_p1[1] <= C_GV * offs(v_word[DATA_W-1:0],        32'sd128);
      bu_p1[0] <= C_BU * offs(u_word[2*DATA_W-1:DATA_W], 32'sd128);
      bu_p1[1] <= C_BU * offs(u_word[DATA_W-1:0],        32'sd128);
    end
  end

  // ---- stage p2: sum, shift and clip ----
  // Sum the products and clip each component
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      r_acc[i] = yk_p1[i] + rv_p1[i];
      g_acc[i] = yk_p1[i] - gu_p1[i] - gv_p1[i];
      b_acc[i] = yk_p1[i] + bu_p1[i];
      r_c[i]   = clip_pix(r_acc[i]);
      g_c[i]   = clip_pix(g_acc[i]);
      b_c[i]   = clip_pix(b_acc[i]);
    end
  end

  // Hold the clipped components for the second and third writes
  always_ff @(posedge Clock) begin
    if (state == S_CALC1) begin
      for (int i = 0; i < 2; i++) begin
        r_p2[i] <= r_c[i];
        g_p2[i] <= g_c[i];
        b_p2[i] <= b_c[i];
      end
    end
  end

  // Registered SRAM interface and status outputs, loaded for the upcoming state
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Busy            <= 1'b0;
      Done            <= 1'b0;
      SRAM_we_n       <= 1'b1;
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
    end else begin
      Done      <= (state_n == S_DONE);
      SRAM_we_n <= 1'b1;
      if (start_acc)            Busy <= 1'b1;
      else if (state == S_DONE) Busy <= 1'b0;
      case (state_n)
        S_RD_Y: SRAM_address <= Y_BASE + {1'b0, pair_cnt_n};
        S_RD_U: SRAM_address <= U_BASE + {1'b0, pair_cnt_n};
        S_RD_V: SRAM_address <= V_BASE + {1'b0, pair_cnt_n};
        S_WR0: begin
          SRAM_address    <= rgb_ptr;
          SRAM_write_data <= {r_c[0], g_c[0]};
          SRAM_we_n       <= 1'b0;
        end
        S_WR1: begin
          SRAM_address    <= rgb_ptr + 18'd1;
          SRAM_write_data <= {b_p2[0], r_p2[1]};
          SRAM_we_n       <= 1'b0;
        end
        S_WR2: begin
          SRAM_address    <= rgb_ptr + 18'd2;
          SRAM_write_data <= {g_p2[1], b_p2[1]};
          SRAM_we_n       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef CSC_CLIP_COUNT_EN
  logic [2:0]  clip_num;
  logic [18:0] clip_sum;

  // Count clipped components of the current pair and form the saturating sum
  always_comb begin
    clip_num = '0;
    for (int i = 0; i < 2; i++) begin
      clip_num = clip_num + {2'b00, is_clipped(r_acc[i])}
                          + {2'b00, is_clipped(g_acc[i])}
                          + {2'b00, is_clipped(b_acc[i])};
    end
    clip_sum = {1'b0, Clip_count} + {16'd0, clip_num};
  end

  // Frame-wide clip counter, saturating at all ones
  always_ff @(posedge Clock) begin
    if (Reset)                Clip_count <= '0;
    else if (start_acc)       Clip_count <= '0;
    else if (state == S_CALC1) Clip_count <= clip_sum[18] ? '1 : clip_sum[17:0];
  end
`endif

endmodule

// File: tb/tb_yuv_to_rgb_sram_converter.sv
// Bench for yuv_to_rgb_sram_converter: SRAM model with 2-cycle read latency,
// write scoreboard fed by the stimulus process, monitor on the falling edge.
module tb_yuv_to_rgb_sram_converter;

  localparam logic [17:0] Y_BASE    = 18'd0;
  localparam logic [17:0] U_BASE    = 18'd38400;
  localparam logic [17:0] V_BASE    = 18'd76800;
  localparam logic [17:0] RGB_BASE  = 18'h3FFF4;
  localparam logic [16:0] NUM_PAIRS = 17'd4;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Busy;
  logic        Done;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
`ifdef CSC_CLIP_COUNT_EN
  logic [17:0] Clip_count;
`endif

  yuv_to_rgb_sram_converter #(
    .Y_BASE(Y_BASE), .U_BASE(U_BASE), .V_BASE(V_BASE),
    .RGB_BASE(RGB_BASE), .NUM_PAIRS(NUM_PAIRS), .SRAM_RD_LAT(2)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Start(Start),
    .Busy(Busy),
    .Done(Done),
    .SRAM_address(SRAM_address),
    .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n),
    .SRAM_read_data(SRAM_read_data)
`ifdef CSC_CLIP_COUNT_EN
    ,
    .Clip_count(Clip_count)
`endif
  );

  always #10 Clock = ~Clock;

  typedef struct packed {
    logic [17:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int we_low_cnt = 0;
  int last_wr0_cyc = 0;
  logic        prev_we_low = 1'b0;
  logic [17:0] prev_addr = '0;

  // Directed pairs: black, nominal white, all-zero (G only), R/B over-range
  logic [15:0] y_tab [4] = '{16'h1010, 16'hEBEB, 16'h0000, 16'hFFFF};
  logic [15:0] u_tab [4] = '{16'h8080, 16'h8080, 16'h0000, 16'h8080};
  logic [15:0] v_tab [4] = '{16'h8080, 16'h8080, 16'h0000, 16'hFFFF};
  // Hand-computed RGB words {R0,G0},{B0,R1},{G1,B1} for each pair
  logic [15:0] rgb_tab [12] = '{16'h0000, 16'h0000, 16'h0000,
                                16'hFEFE, 16'hFEFE, 16'hFEFE,
                                16'h0087, 16'h0000, 16'h8700,
                                16'hFFAE, 16'hFFFF, 16'hAEFF};

  logic [15:0] mem [logic [17:0]];
  logic [15:0] rd_p1, rd_p2;
  assign SRAM_read_data = rd_p2;

  // SRAM model: data appears two cycles after the address is presented
  always @(posedge Clock) begin
    cyc   <= cyc + 1;
    rd_p1 <= mem.exists(SRAM_address) ? mem[SRAM_address] : 16'h0000;
    rd_p2 <= rd_p1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compare every write against the scoreboard, check pair period and Done timing
  always @(negedge Clock) begin
    if (!SRAM_we_n) begin
      we_low_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: actual addr=%h data=%h, required no write",
                 SRAM_address, SRAM_write_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", {14'd0, SRAM_address}, {14'd0, mon_e.a});
        chk("wr_data", {16'd0, SRAM_write_data}, {16'd0, mon_e.d});
      end
      if (((int'(SRAM_address) - int'(RGB_BASE)) % 3) == 0) begin
        if (SRAM_address != RGB_BASE) chk("pair_period", cyc - last_wr0_cyc, 10);
        last_wr0_cyc = cyc;
      end
    end
    if (Done) begin
      done_cnt++;
      chk("done_after_wr2", {13'd0, prev_we_low, prev_addr}, {13'd0, 1'b1, 18'h3FFFF});
    end
    prev_we_low = !SRAM_we_n;
    prev_addr   = SRAM_address;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push_writes(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{a: RGB_BASE + 18'(i), d: rgb_tab[i]});
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    chk(name, done_cnt - d0, 1);
  endtask

  int d0, w0;
  logic found;

  initial begin
    for (int k = 0; k < 4; k++) begin
      mem[Y_BASE + 18'(k)] = y_tab[k];
      mem[U_BASE + 18'(k)] = u_tab[k];
      mem[V_BASE + 18'(k)] = v_tab[k];
    end
    Reset = 1'b1;
    Start = 1'b0;
    repeat (3) tick();
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_we_n", SRAM_we_n, 1);
    chk("rst_addr", SRAM_address, 0);
    chk("rst_wdata", SRAM_write_data, 0);
`ifdef CSC_CLIP_COUNT_EN
    chk("rst_clip", Clip_count, 0);
`endif
    Reset = 1'b0;
    tick();

    // Frame A: full frame with an ignored second Start mid-frame
    d0 = done_cnt;
    w0 = we_low_cnt;
    push_writes(12);
    pulse_start();
    chk("a_busy_after_start", Busy, 1);
    repeat (15) tick();
    pulse_start();
    wait_done(d0, 200, "a_done_seen");
    repeat (3) tick();
    chk("a_done_count", done_cnt - d0, 1);
    chk("a_we_low_cycles", we_low_cnt - w0, 12);
    chk("a_busy_after", Busy, 0);
    chk("a_queue_empty", exp_q.size(), 0);
`ifdef CSC_CLIP_COUNT_EN
    chk("a_clip_count", Clip_count, 8);
`endif

    // Frame B: abort with Reset (plus a coincident Start) while in the second write
    d0 = done_cnt;
    w0 = we_low_cnt;
    push_writes(2);
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (!SRAM_we_n && SRAM_address == RGB_BASE + 18'd1) found = 1'b1;
    end
    chk("b_reached_wr1", found, 1);
    Reset = 1'b1;
    Start = 1'b1;
    tick();
    Reset = 1'b0;
    Start = 1'b0;
    chk("b_we_n_after_rst", SRAM_we_n, 1);
    chk("b_busy_after_rst", Busy, 0);
    chk("b_done_after_rst", Done, 0);
    repeat (30) tick();
    chk("b_no_done", done_cnt - d0, 0);
    chk("b_we_low_cycles", we_low_cnt - w0, 2);
    chk("b_start_with_rst_ignored", Busy, 0);
    chk("b_queue_empty", exp_q.size(), 0);
`ifdef CSC_CLIP_COUNT_EN
    chk("b_clip_cleared", Clip_count, 0);
`endif

    // Frame C: a fresh Start after the abort runs a complete frame
    d0 = done_cnt;
    w0 = we_low_cnt;
    push_writes(12);
    pulse_start();
    wait_done(d0, 200, "c_done_seen");
    repeat (3) tick();
    chk("c_we_low_cycles", we_low_cnt - w0, 12);
    chk("c_busy_after", Busy, 0);
    chk("c_queue_empty", exp_q.size(), 0);
`ifdef CSC_CLIP_COUNT_EN
    chk("c_clip_count", Clip_count, 8);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
